// File: rtl/RV32I_definitions.sv
// RV32I_definitions: shared ALU/branch codes, shifter states and EX pipeline register layout
package RV32I_definitions;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
  } alu_op_e;
  typedef enum logic [2:0] {
    BR_BEQ = 3'b000, BR_BNE = 3'b001, BR_BLT = 3'b100,
    BR_BGE = 3'b101, BR_BLTU = 3'b110, BR_BGEU = 3'b111
  } br_type_e;
  typedef enum logic [1:0] {SH_IDLE, SH_SHIFT, SH_DONE} sh_state_e;
  typedef struct packed {
    logic [31:0] result;
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic [2:0]  mop;
    logic        mw;
    logic        mr;
    logic        m2r;
    logic        rw;
  } ex_reg_t;
  function automatic logic is_shift(input logic [3:0] op);
    return op == ALU_SLL || op == ALU_SRL || op == ALU_SRA;
  endfunction
  function automatic logic br_cmp(input logic [2:0] bt, input logic [31:0] a, input logic [31:0] b);
    case (bt)
      BR_BEQ:  return a == b;
      BR_BNE:  return a != b;
      BR_BLT:  return $signed(a) < $signed(b);
      BR_BGE:  return $signed(a) >= $signed(b);
      BR_BLTU: return a < b;
      BR_BGEU: return a >= b;
      default: return 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/ex_top_if.sv
// ex_top_if: decode->execute bus, writeback forwarding source and EX stage outputs
// master drives ID_*/WB_* and observes EX_*; slave is the execute stage.
interface ex_top_if;
  logic        ID_Valid;
  logic [3:0]  ID_ALU_op;
  logic        ID_ALU_src1_sel;
  logic        ID_ALU_src2_sel;
  logic [31:0] ID_Rs1_data;
  logic [31:0] ID_Rs2_data;
  logic [31:0] ID_Imm;
  logic [31:0] ID_PC;
  logic [4:0]  ID_Rs1_addr;
  logic [4:0]  ID_Rs2_addr;
  logic [4:0]  ID_Rd_addr;
  logic        ID_Branch;
  logic        ID_Jump;
  logic        ID_Jalr;
  logic [2:0]  ID_Branch_type;
  logic        ID_Mem_wr_en;
  logic        ID_Mem_rd_en;
  logic        ID_MemToReg;
  logic        ID_RegFile_wr_en;
  logic [2:0]  ID_Mem_op;
  logic        WB_wr_en;
  logic [4:0]  WB_Rd_addr;
  logic [31:0] WB_wr_data;
  logic [31:0] EX_ALU_result;
  logic [31:0] EX_Rs2_data;
  logic [4:0]  EX_Rd_addr;
  logic [2:0]  EX_Mem_op;
  logic        EX_Mem_wr_en;
  logic        EX_Mem_rd_en;
  logic        EX_MemToReg;
  logic        EX_RegFile_wr_en;
  logic        EX_Branch_taken;
  logic [31:0] EX_Branch_target;
  logic        EX_Stall;
  modport master (
    output ID_Valid, ID_ALU_op, ID_ALU_src1_sel, ID_ALU_src2_sel, ID_Rs1_data, ID_Rs2_data,
           ID_Imm, ID_PC, ID_Rs1_addr, ID_Rs2_addr, ID_Rd_addr, ID_Branch, ID_Jump, ID_Jalr,
           ID_Branch_type, ID_Mem_wr_en, ID_Mem_rd_en, ID_MemToReg, ID_RegFile_wr_en, ID_Mem_op,
           WB_wr_en, WB_Rd_addr, WB_wr_data,
    input  EX_ALU_result, EX_Rs2_data, EX_Rd_addr, EX_Mem_op, EX_Mem_wr_en, EX_Mem_rd_en,
           EX_MemToReg, EX_RegFile_wr_en, EX_Branch_taken, EX_Branch_target, EX_Stall
  );
  modport slave (
    input  ID_Valid, ID_ALU_op, ID_ALU_src1_sel, ID_ALU_src2_sel, ID_Rs1_data, ID_Rs2_data,
           ID_Imm, ID_PC, ID_Rs1_addr, ID_Rs2_addr, ID_Rd_addr, ID_Branch, ID_Jump, ID_Jalr,
           ID_Branch_type, ID_Mem_wr_en, ID_Mem_rd_en, ID_MemToReg, ID_RegFile_wr_en, ID_Mem_op,
           WB_wr_en, WB_Rd_addr, WB_wr_data,
    output EX_ALU_result, EX_Rs2_data, EX_Rd_addr, EX_Mem_op, EX_Mem_wr_en, EX_Mem_rd_en,
           EX_MemToReg, EX_RegFile_wr_en, EX_Branch_taken, EX_Branch_target, EX_Stall
  );
endinterface

// File: rtl/EX_alu.sv
// EX_alu: combinational RV32I ALU; shift amount is b_i[4:0], arithmetic wraps mod 2^32
// op_i: alu_op_e code; a_i/b_i: operands; y_o: result (0 for unused codes).
module EX_alu
  import RV32I_definitions::*;
(
  input  logic [3:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] y_o
);
  always_comb begin
    y_o = '0;
    case (op_i)
      ALU_ADD:    y_o = a_i + b_i;
      ALU_SUB:    y_o = a_i - b_i;
      ALU_SLL:    y_o = a_i << b_i[4:0];
      ALU_SLT:    y_o = {31'd0, $signed(a_i) < $signed(b_i)};
      ALU_SLTU:   y_o = {31'd0, a_i < b_i};
      ALU_XOR:    y_o = a_i ^ b_i;
      ALU_SRL:    y_o = a_i >> b_i[4:0];
      ALU_SRA:    y_o = $signed(a_i) >>> b_i[4:0];
      ALU_OR:     y_o = a_i | b_i;
      ALU_AND:    y_o = a_i & b_i;
      ALU_PASS_B: y_o = b_i;
      default:    y_o = '0;
    endcase
  end
endmodule

// File: rtl/ex_top.sv
// ex_top: RV32I execute stage with forwarding, branch resolution and EX/MEM pipeline register
// Clk/Reset: clock and synchronous active-high reset; bus: ex_top_if.slave (ID_*/WB_* in, EX_* out).
// EX_ITER_SHIFT_EN defined: shifts run on a bit-serial FSM that stalls k+1 cycles;
// undefined: single-cycle barrel shift and EX_Stall tied low.
module ex_top
  import RV32I_definitions::*;
(
  input logic   Clk,
  input logic   Reset,
  ex_top_if.slave bus
);
  ex_reg_t     ex_q, ex_d;
  logic        ex_fwd, wb_fwd, stall, jump;
  logic [31:0] rs1_f, rs2_f, src_a, src_b, alu_y, exec_y;
  // A load in EX has no data yet, so only ALU producers are forwarded from EX.
  assign ex_fwd = ex_q.rw && ex_q.rd != 5'd0 && !ex_q.m2r;
  assign wb_fwd = bus.WB_wr_en && bus.WB_Rd_addr != 5'd0;
  assign rs1_f = ex_fwd && ex_q.rd == bus.ID_Rs1_addr ? ex_q.result :
                 wb_fwd && bus.WB_Rd_addr == bus.ID_Rs1_addr ? bus.WB_wr_data : bus.ID_Rs1_data;
  assign rs2_f = ex_fwd && ex_q.rd == bus.ID_Rs2_addr ? ex_q.result :
                 wb_fwd && bus.WB_Rd_addr == bus.ID_Rs2_addr ? bus.WB_wr_data : bus.ID_Rs2_data;
  assign src_a = bus.ID_ALU_src1_sel ? bus.ID_PC : rs1_f;
  assign src_b = bus.ID_ALU_src2_sel ? bus.ID_Imm : rs2_f;
  EX_alu u_alu (.op_i(bus.ID_ALU_op), .a_i(src_a), .b_i(src_b), .y_o(alu_y));
`ifdef EX_ITER_SHIFT_EN
  sh_state_e   st_q, st_d;
  logic [31:0] sh_q, sh_d;
  logic [4:0]  cnt_q, cnt_d;
  // Upstream holds ID_* during the stall, so the op is read live rather than latched.
  always_comb begin
    st_d = st_q;
    sh_d = sh_q;
    cnt_d = cnt_q;
    stall = 1'b0;
    exec_y = alu_y;
    case (st_q)
      SH_IDLE: if (bus.ID_Valid && is_shift(bus.ID_ALU_op) && src_b[4:0] != 5'd0) begin
        sh_d = src_a;
        cnt_d = src_b[4:0];
        stall = 1'b1;
        st_d = SH_SHIFT;
      end
      SH_SHIFT: begin
        sh_d = bus.ID_ALU_op == ALU_SLL ? {sh_q[30:0], 1'b0} :
               {bus.ID_ALU_op == ALU_SRA && sh_q[31], sh_q[31:1]};
        cnt_d = cnt_q - 5'd1;
        stall = 1'b1;
        st_d = cnt_q == 5'd1 ? SH_DONE : SH_SHIFT;
      end
      SH_DONE: begin
        exec_y = sh_q;
        st_d = SH_IDLE;
      end
      default: st_d = SH_IDLE;
    endcase
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      st_q <= SH_IDLE;
      sh_q <= '0;
      cnt_q <= '0;
    end else begin
      st_q <= st_d;
      sh_q <= sh_d;
      cnt_q <= cnt_d;
    end
  end
`else
  assign stall = 1'b0;
  assign exec_y = alu_y;
`endif
  assign jump = bus.ID_Jump || bus.ID_Jalr;
  assign bus.EX_Branch_taken = bus.ID_Valid && !stall &&
                               (jump || (bus.ID_Branch && br_cmp(bus.ID_Branch_type, rs1_f, rs2_f)));
  assign bus.EX_Branch_target = bus.ID_Jalr ? (rs1_f + bus.ID_Imm) & ~32'h1 : bus.ID_PC + bus.ID_Imm;
  assign bus.EX_Stall = stall;
  assign ex_d = bus.ID_Valid && !stall ? ex_reg_t'{
    result: jump ? bus.ID_PC + 32'd4 : exec_y, rs2: rs2_f, rd: bus.ID_Rd_addr, mop: bus.ID_Mem_op,
    mw: bus.ID_Mem_wr_en, mr: bus.ID_Mem_rd_en, m2r: bus.ID_MemToReg, rw: bus.ID_RegFile_wr_en} : '0;
  always_ff @(posedge Clk) ex_q <= Reset ? '0 : ex_d;
  assign bus.EX_ALU_result = ex_q.result;
  assign bus.EX_Rs2_data = ex_q.rs2;
  assign bus.EX_Rd_addr = ex_q.rd;
  assign bus.EX_Mem_op = ex_q.mop;
  assign bus.EX_Mem_wr_en = ex_q.mw;
  assign bus.EX_Mem_rd_en = ex_q.mr;
  assign bus.EX_MemToReg = ex_q.m2r;
  assign bus.EX_RegFile_wr_en = ex_q.rw;
endmodule

// File: tb/tb_ex_top.sv
// tb_ex_top: table-driven, hand-sequenced and random checks of ex_top against a behavioural model
module tb_ex_top;
  import RV32I_definitions::*;
  typedef struct packed {
    logic valid;
    logic [3:0] op;
    logic s1, s2;
    logic [31:0] rs1, rs2, imm, pc;
    logic [4:0] a1, a2, rd;
    logic br, j, jr;
    logic [2:0] bt;
    logic mw, mr, m2r, rw;
    logic [2:0] mop;
    logic wbe;
    logic [4:0] wba;
    logic [31:0] wbd;
    logic [31:0] e_res, e_tgt;
    logic e_tk;
  } vec_t;
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  int total = 0;
  int bad = 0;
  logic m_wr = 1'b0;
  logic m_m2r = 1'b0;
  logic [4:0] m_rd = '0;
  logic [31:0] m_res = '0;
  always #5 Clk = ~Clk;
  ex_top_if bus();
  ex_top dut (.Clk(Clk), .Reset(Reset), .bus(bus));

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", n, act, exp);
    end
  endtask

  // Register value as seen by the instruction: newest in-flight ALU write, then WB, else decode data.
  function automatic logic [31:0] fwd(input logic [4:0] a, input logic [31:0] d, input vec_t v);
    if (a != 5'd0 && m_wr && !m_m2r && m_rd == a) return m_res;
    if (a != 5'd0 && v.wbe && v.wba == a) return v.wbd;
    return d;
  endfunction

  function automatic vec_t model(input vec_t v);
    logic [31:0] a, b, x, y, s;
    logic [63:0] ext;
    logic tk;
    a = fwd(v.a1, v.rs1, v);
    b = fwd(v.a2, v.rs2, v);
    x = v.s1 ? v.pc : a;
    y = v.s2 ? v.imm : b;
    ext = {{32{x[31]}}, x} >> y[4:0];
    case (v.op)
      ALU_ADD:    v.e_res = x + y;
      ALU_SUB:    v.e_res = x - y;
      ALU_SLL:    v.e_res = x << y[4:0];
      ALU_SLT:    v.e_res = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      ALU_SLTU:   v.e_res = (x < y) ? 32'd1 : 32'd0;
      ALU_XOR:    v.e_res = x ^ y;
      ALU_SRL:    v.e_res = x >> y[4:0];
      ALU_SRA:    v.e_res = ext[31:0];
      ALU_OR:     v.e_res = x | y;
      ALU_AND:    v.e_res = x & y;
      ALU_PASS_B: v.e_res = y;
      default:    v.e_res = 32'd0;
    endcase
    if (v.j || v.jr) v.e_res = v.pc + 32'd4;
    case (v.bt)
      3'd0:    tk = a == b;
      3'd1:    tk = a != b;
      3'd4:    tk = $signed(a) < $signed(b);
      3'd5:    tk = $signed(a) >= $signed(b);
      3'd6:    tk = a < b;
      3'd7:    tk = a >= b;
      default: tk = 1'b0;
    endcase
    v.e_tk = v.valid && (v.j || v.jr || (v.br && tk));
    s = a + v.imm;
    v.e_tgt = v.jr ? {s[31:1], 1'b0} : v.pc + v.imm;
    return v;
  endfunction

  function automatic vec_t mk(input logic [3:0] op, input logic s2, input logic [4:0] a1, input logic [4:0] a2,
                              input logic [4:0] rd, input logic [31:0] rs1, input logic [31:0] rs2,
                              input logic [31:0] imm, input logic [31:0] res);
    vec_t v;
    v = '0;
    v.valid = 1'b1;
    v.op = op;
    v.s2 = s2;
    v.a1 = a1;
    v.a2 = a2;
    v.rd = rd;
    v.rs1 = rs1;
    v.rs2 = rs2;
    v.imm = imm;
    v.rw = 1'b1;
    v.pc = 32'h100;
    v.mop = 3'd2;
    v.e_res = res;
    v.e_tgt = v.pc + imm;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.ID_Valid = v.valid;
    bus.ID_ALU_op = v.op;
    bus.ID_ALU_src1_sel = v.s1;
    bus.ID_ALU_src2_sel = v.s2;
    bus.ID_Rs1_data = v.rs1;
    bus.ID_Rs2_data = v.rs2;
    bus.ID_Imm = v.imm;
    bus.ID_PC = v.pc;
    bus.ID_Rs1_addr = v.a1;
    bus.ID_Rs2_addr = v.a2;
    bus.ID_Rd_addr = v.rd;
    bus.ID_Branch = v.br;
    bus.ID_Jump = v.j;
    bus.ID_Jalr = v.jr;
    bus.ID_Branch_type = v.bt;
    bus.ID_Mem_wr_en = v.mw;
    bus.ID_Mem_rd_en = v.mr;
    bus.ID_MemToReg = v.m2r;
    bus.ID_RegFile_wr_en = v.rw;
    bus.ID_Mem_op = v.mop;
    bus.WB_wr_en = v.wbe;
    bus.WB_Rd_addr = v.wba;
    bus.WB_wr_data = v.wbd;
  endtask

  task automatic chk_zero(input string n);
    chk({n, "_res"}, bus.EX_ALU_result, 32'd0);
    chk({n, "_rs2"}, bus.EX_Rs2_data, 32'd0);
    chk({n, "_rd"}, 32'(bus.EX_Rd_addr), 32'd0);
    chk({n, "_ctl"}, 32'({bus.EX_Mem_op, bus.EX_Mem_wr_en, bus.EX_Mem_rd_en, bus.EX_MemToReg,
                          bus.EX_RegFile_wr_en}), 32'd0);
    chk({n, "_stall"}, 32'(bus.EX_Stall), 32'd0);
  endtask

  task automatic apply(input vec_t v);
    logic [31:0] r2;
    logic on;
    r2 = fwd(v.a2, v.rs2, v);
    on = v.valid;
    drive(v);
    #1;
    chk("taken", 32'(bus.EX_Branch_taken), 32'(v.e_tk));
    chk("target", bus.EX_Branch_target, v.e_tgt);
    chk("stall", 32'(bus.EX_Stall), 32'd0);
    @(posedge Clk);
    #1;
    chk("result", bus.EX_ALU_result, on ? v.e_res : 32'd0);
    chk("rd", 32'(bus.EX_Rd_addr), on ? 32'(v.rd) : 32'd0);
    chk("rs2", bus.EX_Rs2_data, on ? r2 : 32'd0);
    chk("ctl", 32'({bus.EX_Mem_op, bus.EX_Mem_wr_en, bus.EX_Mem_rd_en, bus.EX_MemToReg, bus.EX_RegFile_wr_en}),
        on ? 32'({v.mop, v.mw, v.mr, v.m2r, v.rw}) : 32'd0);
    m_wr = on && v.rw;
    m_m2r = on && v.m2r;
    m_rd = on ? v.rd : 5'd0;
    m_res = on ? v.e_res : 32'd0;
  endtask

  task automatic run_shift(input logic [3:0] op, input logic [31:0] val, input logic [31:0] b,
                           input logic s2, input logic [31:0] exp);
    vec_t v;
    int n, exp_n;
    v = mk(op, s2, 5'd30, 5'd31, 5'd16, val, s2 ? 32'd0 : b, s2 ? b : 32'd0, exp);
`ifdef EX_ITER_SHIFT_EN
    exp_n = b[4:0] == 5'd0 ? 0 : int'(b[4:0]) + 1;
`else
    exp_n = 0;
`endif
    drive(v);
    #1;
    n = 0;
    while (bus.EX_Stall === 1'b1 && n < 64) begin
      chk("stall_taken", 32'(bus.EX_Branch_taken), 32'd0);
      @(posedge Clk);
      #1;
      n++;
      chk("stall_bubble", 32'(bus.EX_RegFile_wr_en), 32'd0);
    end
    chk("stall_len", n, exp_n);
    @(posedge Clk);
    #1;
    chk("shift_res", bus.EX_ALU_result, exp);
    chk("shift_wr", 32'(bus.EX_RegFile_wr_en), 32'd1);
    m_wr = 1'b1;
    m_m2r = 1'b0;
    m_rd = 5'd16;
    m_res = exp;
  endtask

  initial begin
    vec_t tbl[$];
    vec_t t;
    logic [3:0] safe_ops [8] = '{ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_OR, ALU_AND, ALU_PASS_B};
    int r;
    drive('0);
    repeat (2) @(posedge Clk);
    #1;
    chk_zero("reset");
    Reset = 1'b0;
    tbl.push_back(mk(ALU_ADD, 1, 1, 30, 7, 32'h7FFFFFFF, 0, 1, 32'h80000000));
    tbl.push_back(mk(ALU_ADD, 1, 3, 30, 5, 10, 0, 0, 10));
    t = mk(ALU_ADD, 0, 5, 5, 6, 1, 1, 0, 20); t.wbe = 1; t.wba = 5; t.wbd = 3; tbl.push_back(t);
    t = mk(ALU_ADD, 0, 6, 5, 0, 1, 100, 0, 23); t.wbe = 1; t.wba = 5; t.wbd = 3; tbl.push_back(t);
    t = mk(ALU_ADD, 0, 0, 0, 9, 4, 5, 0, 9); t.wbe = 1; t.wba = 0; t.wbd = 99; tbl.push_back(t);
    tbl.push_back(mk(ALU_SUB, 0, 10, 11, 12, 5, 7, 0, 32'hFFFFFFFE));
    tbl.push_back(mk(ALU_SLT, 0, 10, 11, 12, 32'hFFFFFFFF, 1, 0, 1));
    tbl.push_back(mk(ALU_SLTU, 0, 10, 11, 12, 32'hFFFFFFFF, 1, 0, 0));
    tbl.push_back(mk(ALU_XOR, 0, 10, 11, 12, 32'hF0F0, 32'hFF00, 0, 32'h0FF0));
    tbl.push_back(mk(ALU_OR, 0, 10, 11, 12, 32'hF0F0, 32'hFF00, 0, 32'hFFF0));
    tbl.push_back(mk(ALU_AND, 0, 10, 11, 12, 32'hF0F0, 32'hFF00, 0, 32'hF000));
    tbl.push_back(mk(ALU_PASS_B, 1, 10, 11, 13, 5, 0, 32'h12345000, 32'h12345000));
    t = mk(ALU_ADD, 0, 20, 21, 0, 32'hFFFFFFFF, 1, 32'h20, 0); t.rw = 0; t.br = 1; t.bt = 3'b100; t.e_tk = 1; tbl.push_back(t);
    t.bt = 3'b110; t.e_tk = 0; tbl.push_back(t);
    t = mk(ALU_ADD, 0, 20, 21, 0, 1, 32'hFFFFFFFF, 32'h20, 0); t.rw = 0; t.br = 1; t.bt = 3'b101; t.e_tk = 1; tbl.push_back(t);
    t.bt = 3'b111; t.e_tk = 0; tbl.push_back(t);
    t = mk(ALU_ADD, 0, 20, 21, 0, 7, 7, 32'h8, 14); t.rw = 0; t.br = 1; t.bt = 3'b000; t.e_tk = 1; tbl.push_back(t);
    t.bt = 3'b001; t.e_tk = 0; tbl.push_back(t);
    t = mk(ALU_ADD, 1, 20, 21, 1, 32'h1003, 0, 0, 32'h44); t.jr = 1; t.pc = 32'h40; t.e_tgt = 32'h1002; t.e_tk = 1; tbl.push_back(t);
    t = mk(ALU_ADD, 1, 20, 21, 2, 0, 0, 32'h10, 32'h204); t.j = 1; t.pc = 32'h200; t.e_tgt = 32'h210; t.e_tk = 1; tbl.push_back(t);
    t = mk(ALU_ADD, 1, 20, 21, 3, 1, 1, 0, 0); t.valid = 0; t.j = 1; tbl.push_back(t);
    t = mk(ALU_ADD, 1, 20, 21, 14, 5, 0, 0, 5); t.m2r = 1; t.mr = 1; tbl.push_back(t);
    tbl.push_back(mk(ALU_ADD, 0, 14, 21, 15, 100, 1, 0, 101));
    foreach (tbl[i]) apply(tbl[i]);
    run_shift(ALU_SRA, 32'h80000000, 3, 1, 32'hF0000000);
    run_shift(ALU_SLL, 32'h1, 31, 1, 32'h80000000);
    run_shift(ALU_SRL, 32'h80000000, 31, 1, 32'h1);
    run_shift(ALU_SRA, 32'h7FFFFFFF, 4, 1, 32'h07FFFFFF);
    run_shift(ALU_SLL, 32'h1234, 0, 1, 32'h1234);
    run_shift(ALU_SRL, 32'hF0, 32'hFFFFFFE5, 0, 32'h7);
    apply(mk(ALU_ADD, 1, 16, 31, 17, 0, 0, 1, 8));
    for (int i = 0; i < 300; i++) begin
      t = '0;
      t.valid = $urandom_range(9) != 0;
`ifdef EX_ITER_SHIFT_EN
      t.op = safe_ops[$urandom_range(7)];
`else
      t.op = 4'($urandom_range(10));
`endif
      t.s1 = 1'($urandom);
      t.s2 = 1'($urandom);
      t.rs1 = $urandom_range(1) != 0 ? $urandom : 32'($urandom_range(40));
      t.rs2 = $urandom_range(1) != 0 ? $urandom : 32'($urandom_range(40));
      t.imm = $urandom;
      t.pc = $urandom & 32'hFFFF_FFFC;
      t.a1 = 5'($urandom_range(3));
      t.a2 = 5'($urandom_range(3));
      t.rd = 5'($urandom_range(3));
      r = $urandom_range(7);
      t.br = r == 0 || r == 3;
      t.j = r == 1;
      t.jr = r == 2;
      t.bt = 3'($urandom);
      t.mw = 1'($urandom);
      t.mr = 1'($urandom);
      t.m2r = $urandom_range(3) == 0;
      t.rw = 1'($urandom);
      t.mop = 3'($urandom);
      t.wbe = 1'($urandom);
      t.wba = 5'($urandom_range(3));
      t.wbd = $urandom;
      apply(model(t));
    end
    drive(mk(ALU_SRA, 1, 30, 31, 18, 32'h80000000, 0, 8, 32'hFF800000));
    repeat (3) begin
      @(posedge Clk);
      #1;
    end
`ifdef EX_ITER_SHIFT_EN
    chk("mid_shift_stall", 32'(bus.EX_Stall), 32'd1);
`else
    chk("pre_reset_res", bus.EX_ALU_result, 32'hFF800000);
`endif
    Reset = 1'b1;
    bus.ID_Valid = 1'b0;
    @(posedge Clk);
    #1;
    chk_zero("midrst");
    Reset = 1'b0;
    repeat (10) @(posedge Clk);
    #1;
    chk_zero("post_rst");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
